// File: rtl/fpu_op_scheduler_if.sv
// Bundle of every non-clock/reset signal of fpu_op_scheduler.
//   slave  : scheduler side (takes requests, drives the fpu operands, returns responses)
//   master : environment side (requesters, fpu result/flags, response consumer)
// Signals: req{0,1}_{valid,ready,sp_dp,op,a,b}, fpu_{sp_dp,opCode,a_sp,b_sp,a_dp,b_dp},
//          fpu_{result_sp,result_dp,overflow,underflow}, rsp_{valid,ready,id,data,overflow,
//          underflow}, sticky_{ovf,unf}, clr_sticky, busy.
interface fpu_op_scheduler_if;
   logic        req0_valid;
   logic        req0_ready;
   logic        req0_sp_dp;
   logic [1:0]  req0_op;
   logic [63:0] req0_a;
   logic [63:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic        req1_sp_dp;
   logic [1:0]  req1_op;
   logic [63:0] req1_a;
   logic [63:0] req1_b;
   logic        fpu_sp_dp;
   logic [1:0]  fpu_opCode;
   logic [31:0] fpu_a_sp;
   logic [31:0] fpu_b_sp;
   logic [63:0] fpu_a_dp;
   logic [63:0] fpu_b_dp;
   logic [31:0] fpu_result_sp;
   logic [63:0] fpu_result_dp;
   logic        fpu_overflow;
   logic        fpu_underflow;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [63:0] rsp_data;
   logic        rsp_overflow;
   logic        rsp_underflow;
   logic        sticky_ovf;
   logic        sticky_unf;
   logic        clr_sticky;
   logic        busy;

   modport slave (
      input  req0_valid, req0_sp_dp, req0_op, req0_a, req0_b,
      input  req1_valid, req1_sp_dp, req1_op, req1_a, req1_b,
      input  fpu_result_sp, fpu_result_dp, fpu_overflow, fpu_underflow,
      input  rsp_ready, clr_sticky,
      output req0_ready, req1_ready,
      output fpu_sp_dp, fpu_opCode, fpu_a_sp, fpu_b_sp, fpu_a_dp, fpu_b_dp,
      output rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_underflow,
      output sticky_ovf, sticky_unf, busy
   );

   modport master (
      output req0_valid, req0_sp_dp, req0_op, req0_a, req0_b,
      output req1_valid, req1_sp_dp, req1_op, req1_a, req1_b,
      output fpu_result_sp, fpu_result_dp, fpu_overflow, fpu_underflow,
      output rsp_ready, clr_sticky,
      input  req0_ready, req1_ready,
      input  fpu_sp_dp, fpu_opCode, fpu_a_sp, fpu_b_sp, fpu_a_dp, fpu_b_dp,
      input  rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_underflow,
      input  sticky_ovf, sticky_unf, busy
   );
endinterface

// File: rtl/fpu_op_scheduler.sv
// Shares one combinational fpu between two requesters with round-robin arbitration.
// The accepted operands are held on the fpu inputs for LAT(op) cycles (multicycle path),
// then result and flags are captured into a response register held until rsp_ready.
// Ports: clk, rst_n (async, active low), bus (fpu_op_scheduler_if.slave, all other signals).
module fpu_op_scheduler #(
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned DIV_LAT = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   fpu_op_scheduler_if.slave bus
);
   localparam int unsigned MaxAm  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int unsigned MaxLat = (MaxAm > DIV_LAT) ? MaxAm : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   typedef logic [CntW-1:0] cnt_t;
   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   // Counter preload: the capture happens on the edge where the counter is already zero.
   function automatic cnt_t lat_m1(input logic [1:0] op);
      case (op)
         2'b10:   lat_m1 = cnt_t'(MUL_LAT - 1);
         2'b11:   lat_m1 = cnt_t'(DIV_LAT - 1);
         default: lat_m1 = cnt_t'(ADD_LAT - 1);
      endcase
   endfunction

   state_e      state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic        prio_q, prio_d;  // 1: req1 wins a tie
   logic        id_q, id_d;
   logic        sp_dp_q, sp_dp_d;
   logic [1:0]  op_q, op_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [63:0] rsp_data_q, rsp_data_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic        rsp_unf_q, rsp_unf_d;
   logic        sticky_ovf_q, sticky_ovf_d;
   logic        sticky_unf_q, sticky_unf_d;
   logic        gnt0, gnt1, capture;

   assign gnt0 = (state_q == StIdle) && bus.req0_valid && (!bus.req1_valid || !prio_q);
   assign gnt1 = (state_q == StIdle) && bus.req1_valid && (!bus.req0_valid || prio_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prio_d      = prio_q;
      id_d        = id_q;
      sp_dp_d     = sp_dp_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_ovf_d   = rsp_ovf_q;
      rsp_unf_d   = rsp_unf_q;
      capture     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gnt0 || gnt1) begin
               id_d    = gnt1;
               sp_dp_d = gnt1 ? bus.req1_sp_dp : bus.req0_sp_dp;
               op_d    = gnt1 ? bus.req1_op : bus.req0_op;
               a_d     = gnt1 ? bus.req1_a : bus.req0_a;
               b_d     = gnt1 ? bus.req1_b : bus.req0_b;
               cnt_d   = lat_m1(op_d);
               prio_d  = gnt0;
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - cnt_t'(1);
            end else begin
               capture     = 1'b1;
               rsp_data_d  = sp_dp_q ? bus.fpu_result_dp : {32'b0, bus.fpu_result_sp};
               rsp_ovf_d   = bus.fpu_overflow;
               rsp_unf_d   = bus.fpu_underflow;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A flag captured on the same edge as a clear survives.
      sticky_ovf_d = (sticky_ovf_q & ~bus.clr_sticky) | (capture & bus.fpu_overflow);
      sticky_unf_d = (sticky_unf_q & ~bus.clr_sticky) | (capture & bus.fpu_underflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         prio_q       <= 1'b0;
         id_q         <= 1'b0;
         sp_dp_q      <= 1'b0;
         op_q         <= 2'b0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_ovf_q    <= 1'b0;
         rsp_unf_q    <= 1'b0;
         sticky_ovf_q <= 1'b0;
         sticky_unf_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prio_q       <= prio_d;
         id_q         <= id_d;
         sp_dp_q      <= sp_dp_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_unf_q    <= rsp_unf_d;
         sticky_ovf_q <= sticky_ovf_d;
         sticky_unf_q <= sticky_unf_d;
      end
   end

   assign bus.req0_ready    = gnt0;
   assign bus.req1_ready    = gnt1;
   assign bus.fpu_sp_dp     = sp_dp_q;
   assign bus.fpu_opCode    = op_q;
   assign bus.fpu_a_sp      = a_q[31:0];
   assign bus.fpu_b_sp      = b_q[31:0];
   assign bus.fpu_a_dp      = a_q;
   assign bus.fpu_b_dp      = b_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = rsp_id_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.rsp_overflow  = rsp_ovf_q;
   assign bus.rsp_underflow = rsp_unf_q;
   assign bus.sticky_ovf    = sticky_ovf_q;
   assign bus.sticky_unf    = sticky_unf_q;
   assign bus.busy          = (state_q != StIdle);
endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler: behavioural fpu stub (real arithmetic) plus a transaction-level
// model of arbitration, latency, response hold and sticky flags.
module tb_fpu_op_scheduler;
   localparam int unsigned ADD_LAT = 2;
   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned DIV_LAT = 6;

   typedef struct packed {
      logic [31:0] sp;
      logic [63:0] dp;
      logic        ovf;
      logic        unf;
   } fres_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fpu_op_scheduler_if bus_if ();

   fpu_op_scheduler #(
      .ADD_LAT(ADD_LAT),
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   // Single precision widened to real; denormals flush to zero.
   function automatic real sp_to_real(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic real arith(input logic [1:0] op, input real x, input real y);
      case (op)
         2'b00:   return x + y;
         2'b01:   return x - y;
         2'b10:   return x * y;
         default: return x / y;
      endcase
   endfunction

   function automatic fres_t fpu_eval(input logic sp_dp, input logic [1:0] op,
                                      input logic [31:0] a_sp, input logic [31:0] b_sp,
                                      input logic [63:0] a_dp, input logic [63:0] b_dp);
      fres_t       r;
      real         rs, rd;
      logic [63:0] d;
      int          se;
      logic        sovf, sunf, dovf, dunf;
      rs   = arith(op, sp_to_real(a_sp), sp_to_real(b_sp));
      d    = $realtobits(rs);
      se   = int'(d[62:52]) - 896;
      sovf = 1'b0;
      sunf = 1'b0;
      if (rs == 0.0) begin
         r.sp = {d[63], 31'd0};
      end else if (se >= 255) begin
         r.sp = {d[63], 8'hFF, 23'd0};
         sovf = 1'b1;
      end else if (se <= 0) begin
         r.sp = {d[63], 31'd0};
         sunf = 1'b1;
      end else begin
         r.sp = {d[63], se[7:0], d[51:29]};
      end
      rd    = arith(op, $bitstoreal(a_dp), $bitstoreal(b_dp));
      r.dp  = $realtobits(rd);
      dovf  = (r.dp[62:52] == 11'h7FF);
      dunf  = (r.dp[62:52] == 11'd0) && (r.dp[51:0] != 52'd0);
      r.ovf = sp_dp ? dovf : sovf;
      r.unf = sp_dp ? dunf : sunf;
      return r;
   endfunction

   fres_t fpu_out;
   always_comb begin
      fpu_out = fpu_eval(bus_if.fpu_sp_dp, bus_if.fpu_opCode, bus_if.fpu_a_sp, bus_if.fpu_b_sp,
                         bus_if.fpu_a_dp, bus_if.fpu_b_dp);
   end
   assign bus_if.fpu_result_sp = fpu_out.sp;
   assign bus_if.fpu_result_dp = fpu_out.dp;
   assign bus_if.fpu_overflow  = fpu_out.ovf;
   assign bus_if.fpu_underflow = fpu_out.unf;

   // Model state
   bit          pend [2];
   logic        p_sp [2];
   logic [1:0]  p_op [2];
   logic [63:0] p_a  [2];
   logic [63:0] p_b  [2];
   int          prio_m = 0;
   bit          st_ovf = 1'b0;
   bit          st_unf = 1'b0;
   logic        last_id;
   logic        last_ovf;
   logic [63:0] last_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic drive_reqs();
      bus_if.req0_valid = pend[0];
      bus_if.req0_sp_dp = p_sp[0];
      bus_if.req0_op    = p_op[0];
      bus_if.req0_a     = p_a[0];
      bus_if.req0_b     = p_b[0];
      bus_if.req1_valid = pend[1];
      bus_if.req1_sp_dp = p_sp[1];
      bus_if.req1_op    = p_op[1];
      bus_if.req1_a     = p_a[1];
      bus_if.req1_b     = p_b[1];
   endtask

   task automatic set_req(input int i, input logic sp, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b);
      pend[i] = 1'b1;
      p_sp[i] = sp;
      p_op[i] = op;
      p_a[i]  = a;
      p_b[i]  = b;
   endtask

   function automatic logic [63:0] rand_dp();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return {r[63], 11'(1003 + $urandom_range(0, 40)), r[51:0]};
   endfunction

   function automatic logic [31:0] rand_sp();
      logic [31:0] r;
      r = $urandom;
      return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
   endfunction

   task automatic rand_req(input int i);
      logic sp;
      sp = 1'($urandom_range(0, 1));
      if (sp) set_req(i, sp, 2'($urandom_range(0, 3)), rand_dp(), rand_dp());
      else    set_req(i, sp, 2'($urandom_range(0, 3)), {$urandom, rand_sp()},
                      {$urandom, rand_sp()});
   endtask

   function automatic int lat_of(input logic [1:0] op);
      if (op == 2'b10) return int'(MUL_LAT);
      if (op == 2'b11) return int'(DIV_LAT);
      return int'(ADD_LAT);
   endfunction

   task automatic check_fpu_held(input logic sp, input logic [1:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
      check("fpu_sp_dp", 64'(bus_if.fpu_sp_dp), 64'(sp));
      check("fpu_opCode", 64'(bus_if.fpu_opCode), 64'(op));
      check("fpu_a_sp", 64'(bus_if.fpu_a_sp), {32'd0, a[31:0]});
      check("fpu_b_sp", 64'(bus_if.fpu_b_sp), {32'd0, b[31:0]});
      check("fpu_a_dp", bus_if.fpu_a_dp, a);
      check("fpu_b_dp", bus_if.fpu_b_dp, b);
   endtask

   // One full transaction: arbitration, hold, capture, optional stall, handshake.
   task automatic run_op(input int stall, input bit clr_at_cap, input bit clr_at_acc);
      int          g, lat, n;
      logic        sp;
      logic [1:0]  op;
      logic [63:0] a, b, want_data;
      fres_t       er;
      drive_reqs();
      bus_if.clr_sticky = clr_at_acc;
      #1;
      if (pend[0] && pend[1]) g = prio_m;
      else g = pend[1] ? 1 : 0;
      check("req0_ready", 64'(bus_if.req0_ready), 64'(pend[0] && g == 0));
      check("req1_ready", 64'(bus_if.req1_ready), 64'(pend[1] && g == 1));
      check("busy_idle", 64'(bus_if.busy), 64'd0);
      sp = p_sp[g];
      op = p_op[g];
      a  = p_a[g];
      b  = p_b[g];
      @(posedge clk);
      #1;
      prio_m  = 1 - g;
      pend[g] = 1'b0;
      if (clr_at_acc) begin
         st_ovf = 1'b0;
         st_unf = 1'b0;
      end
      bus_if.clr_sticky = 1'b0;
      drive_reqs();
      lat = lat_of(op);
      er  = fpu_eval(sp, op, a[31:0], b[31:0], a, b);
      want_data = sp ? er.dp : {32'd0, er.sp};
      n = 0;
      while (!bus_if.rsp_valid && n <= 20) begin
         check_fpu_held(sp, op, a, b);
         check("busy_exec", 64'(bus_if.busy), 64'd1);
         if (clr_at_cap && n == lat - 1) bus_if.clr_sticky = 1'b1;
         @(posedge clk);
         #1;
         bus_if.clr_sticky = 1'b0;
         n++;
      end
      check("latency", 64'(n), 64'(lat));
      if (clr_at_cap) begin
         st_ovf = 1'b0;
         st_unf = 1'b0;
      end
      st_ovf = st_ovf | er.ovf;
      st_unf = st_unf | er.unf;
      check("rsp_data", bus_if.rsp_data, want_data);
      check("rsp_id", 64'(bus_if.rsp_id), 64'(g));
      check("rsp_overflow", 64'(bus_if.rsp_overflow), 64'(er.ovf));
      check("rsp_underflow", 64'(bus_if.rsp_underflow), 64'(er.unf));
      check("sticky_ovf", 64'(bus_if.sticky_ovf), 64'(st_ovf));
      check("sticky_unf", 64'(bus_if.sticky_unf), 64'(st_unf));
      last_id   = bus_if.rsp_id;
      last_ovf  = bus_if.rsp_overflow;
      last_data = bus_if.rsp_data;
      repeat (stall) begin
         @(posedge clk);
         #1;
         check("stall_valid", 64'(bus_if.rsp_valid), 64'd1);
         check("stall_data", bus_if.rsp_data, want_data);
         check("stall_id", 64'(bus_if.rsp_id), 64'(g));
         check("stall_ovf", 64'(bus_if.rsp_overflow), 64'(er.ovf));
         check("stall_busy", 64'(bus_if.busy), 64'd1);
         check_fpu_held(sp, op, a, b);
      end
      bus_if.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.rsp_ready = 1'b0;
      check("rsp_valid_drop", 64'(bus_if.rsp_valid), 64'd0);
      check("busy_done", 64'(bus_if.busy), 64'd0);
      check_fpu_held(sp, op, a, b);
   endtask

   task automatic idle_clr();
      drive_reqs();
      bus_if.clr_sticky = 1'b1;
      @(posedge clk);
      #1;
      bus_if.clr_sticky = 1'b0;
      st_ovf = 1'b0;
      st_unf = 1'b0;
      check("clr_ovf", 64'(bus_if.sticky_ovf), 64'd0);
      check("clr_unf", 64'(bus_if.sticky_unf), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rsp_valid"}, 64'(bus_if.rsp_valid), 64'd0);
      check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
      check({tag, "_rsp_data"}, bus_if.rsp_data, 64'd0);
      check({tag, "_fpu_a_dp"}, bus_if.fpu_a_dp, 64'd0);
      check({tag, "_fpu_op"}, 64'({bus_if.fpu_sp_dp, bus_if.fpu_opCode}), 64'd0);
      check({tag, "_sticky"}, 64'({bus_if.sticky_ovf, bus_if.sticky_unf}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 2; i++) set_req(i, 1'b0, 2'b00, 64'd0, 64'd0);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive_reqs();
      bus_if.rsp_ready  = 1'b0;
      bus_if.clr_sticky = 1'b0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Both requesters hold DP mul 2.0 x 3.0; grants alternate starting with req0.
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 2; r++)
            if (!pend[r]) set_req(r, 1'b1, 2'b10, 64'h4000000000000000, 64'h4008000000000000);
         run_op(0, 1'b0, 1'b0);
         check("alt_id", 64'(last_id), 64'(i % 2));
         check("mul_data", last_data, 64'h4018000000000000);
      end
      pend[0] = 1'b0;
      pend[1] = 1'b0;

      // Only req0: SP add 1.0 + 2.0.
      set_req(0, 1'b0, 2'b00, 64'h3F800000, 64'h40000000);
      run_op(0, 1'b0, 1'b0);
      check("add_data", last_data, 64'h0000000040400000);
      check("add_id", 64'(last_id), 64'd0);

      // DP div with a five-cycle consumer stall.
      set_req(0, 1'b1, 2'b11, 64'h4018000000000000, 64'h4000000000000000);
      run_op(5, 1'b0, 1'b0);
      check("div_data", last_data, 64'h4008000000000000);

      // SP overflow, idle clear, then clear colliding with a capture.
      set_req(1, 1'b0, 2'b10, 64'h7F000000, 64'h7F000000);
      run_op(1, 1'b0, 1'b0);
      check("ovf_flag", 64'(last_ovf), 64'd1);
      check("ovf_sticky", 64'(bus_if.sticky_ovf), 64'd1);
      idle_clr();
      set_req(0, 1'b0, 2'b10, 64'h7F000000, 64'h7F000000);
      run_op(0, 1'b1, 1'b0);
      check("set_wins", 64'(bus_if.sticky_ovf), 64'd1);

      // Reset in the middle of a divide.
      set_req(1, 1'b1, 2'b11, rand_dp(), rand_dp());
      drive_reqs();
      @(posedge clk);
      #1;
      pend[1] = 1'b0;
      drive_reqs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n  = 1'b1;
      prio_m = 0;
      st_ovf = 1'b0;
      st_unf = 1'b0;
      seen   = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         seen = seen | bus_if.rsp_valid | bus_if.busy;
      end
      check("no_rsp_after_rst", 64'(seen), 64'd0);
      set_req(0, 1'b0, 2'b01, 64'h40400000, 64'h3F800000);
      set_req(1, 1'b1, 2'b00, rand_dp(), rand_dp());
      run_op(0, 1'b0, 1'b0);
      check("post_rst_id", 64'(last_id), 64'd0);
      check("post_rst_data", last_data, 64'h0000000040000000);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         for (int r = 0; r < 2; r++)
            if (!pend[r] && $urandom_range(0, 2) != 0) rand_req(r);
         if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
         run_op(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Shares one combinational `fpu` instance between two requesters.
- Uses round-robin arbitration and a valid/ready handshake on each side.
- Holds the selected operands stable on the `fpu` inputs for a per-opcode number of cycles, which makes the FPU a multicycle path. It then captures the result and exception flags into a response register.
- Sits between the issue logic and the `fpu`. It also keeps sticky overflow/underflow status.

Parameters:
- ADD_LAT, 2: cycles the operands are held before capture for opCode 00/01. Minimum 1.
- MUL_LAT, 3: cycles held for opCode 10. Minimum 1.
- DIV_LAT, 6: cycles held for opCode 11. Minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle (when valid is also high)
- req0_sp_dp  in  1  0 = single precision, 1 = double precision
- req0_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req0_a, req0_b  in  64 each  operands; SP uses bits [31:0]
- req1_valid, req1_ready, req1_sp_dp, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- fpu_sp_dp  out  1  to the `fpu`
- fpu_opCode  out  2  to the `fpu`
- fpu_a_sp, fpu_b_sp  out  32 each  to the `fpu`
- fpu_a_dp, fpu_b_dp  out  64 each  to the `fpu`
- fpu_result_sp  in  32  from the `fpu`
- fpu_result_dp  in  64  from the `fpu`
- fpu_overflow, fpu_underflow  in  1 each  from the `fpu`
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  index of the requester that issued the operation
- rsp_data  out  64  result; SP results are zero-extended from [31:0]
- rsp_overflow, rsp_underflow  out  1 each  flags of this operation
- sticky_ovf, sticky_unf  out  1 each  OR of all captured flags since the last clear
- clr_sticky  in  1  synchronous clear of the sticky flags
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, rr pointer favours req0.
  - All outputs and operand/response registers are 0.
  - Any in-flight operation is dropped; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the one not granted last is granted.
  - reqN_ready = (state==IDLE) && grant==N, combinational. It is never high for both requesters.
- IDLE, acceptance (valid && ready at an edge):
  - Register sp_dp, op, a, b and the id onto the fpu_* outputs. SP operand ports take [31:0]; DP ports take the full 64 bits.
  - Load counter = LAT(op) − 1, update the rr pointer, go to EXEC.
- EXEC:
  - fpu_* outputs are held constant.
  - At each edge: if counter≠0, decrement.
  - If counter==0: capture rsp_data (fpu_result_dp if sp_dp, else {32'b0, fpu_result_sp}), rsp_overflow, rsp_underflow and rsp_id. Set rsp_valid=1 and go to RESP.
- Latency: with acceptance at edge t0, rsp_valid is first high after edge t0+LAT(op).
- RESP:
  - All rsp_* outputs stay stable while rsp_valid=1 && rsp_ready=0.
  - At an edge with rsp_ready=1: rsp_valid←0, go to IDLE.
  - The next acceptance happens no earlier than the following edge. Minimum issue interval is LAT+2 cycles.
- fpu_* outputs keep their last values in IDLE and RESP; they change only on acceptance.
- Sticky flags:
  - At the capture edge, sticky_x ← sticky_x | captured flag.
  - clr_sticky clears them. If a capture and clr_sticky fall on the same edge, the captured flag is set (set wins over clear).
- Inputs sampled while not in IDLE are ignored; requesters hold their requests until ready.

Test Plan:
- Only req0 valid, SP add a=0x3F800000, b=0x40000000, rsp_ready=1 → req0_ready in IDLE; rsp_valid after edge t0+2; rsp_data=0x0000000040400000; rsp_id=0.
- Both valid after reset, DP mul 2.0×3.0 (0x4000000000000000, 0x4008000000000000), both held → req0 served first, rsp_data=0x4018000000000000 at t0+3. req1 granted next; grant alternates 0,1,0,1 across 4 ops.
- DP div with DIV_LAT=6, rsp_ready held low for 5 cycles → fpu_* inputs constant for all 6 EXEC cycles; rsp_* stable while stalled; busy=1 until the rsp_ready edge.
- SP mul 0x7F000000×0x7F000000 → rsp_overflow=1, sticky_ovf=1. Pulse clr_sticky on a later idle cycle → sticky_ovf=0. clr_sticky on the capture edge of an overflowing op → sticky_ovf stays 1.
- Deassert rst_n mid-EXEC → all outputs 0 immediately, no response after release; next request is accepted normally with req0 priority.
